// File: rtl/fetch_unit_pkg.sv
// Shared Y86 encodings: icodes, status codes, ALU function and condition codes,
// plus the fetch FSM state type.
package fetch_unit_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVL = 4'h2;
  localparam logic [3:0] IIRMOVL = 4'h3;
  localparam logic [3:0] IRMMOVL = 4'h4;
  localparam logic [3:0] IMRMOVL = 4'h5;
  localparam logic [3:0] IOPL    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHL  = 4'hA;
  localparam logic [3:0] IPOPL   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_INS = 2'd2;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  typedef enum logic [2:0] {
    StOp,
    StReg,
    StConst,
    StIssue,
    StStop
  } fetch_state_e;

endpackage

// File: rtl/instr_len.sv
// Combinational icode decode: which extra bytes follow the opcode and the
// total instruction length in bytes.
module instr_len
  import fetch_unit_pkg::*;
(
  input  logic [3:0] icode,
  output logic       need_reg,
  output logic       need_const,
  output logic [2:0] length,
  output logic       invalid
);

  always_comb begin
    need_reg   = 1'b0;
    need_const = 1'b0;
    length     = 3'd1;
    invalid    = 1'b0;
    unique case (icode)
      IHALT, INOP, IRET: length = 3'd1;
      IRRMOVL, IOPL, IPUSHL, IPOPL: begin
        need_reg = 1'b1;
        length   = 3'd2;
      end
      IJXX, ICALL: begin
        need_const = 1'b1;
        length     = 3'd5;
      end
      IIRMOVL, IRMMOVL, IMRMOVL: begin
        need_reg   = 1'b1;
        need_const = 1'b1;
        length     = 3'd6;
      end
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Byte-serial Y86 instruction fetch: reads opcode, register and constant bytes
// from a req/ack memory port and hands decoded fields to execute via valid/ready.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [7:0]  imem_rdata,
  input  logic        pc_load,
  input  logic [31:0] pc_new,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [31:0] valC,
  output logic [31:0] valP,
  output logic [1:0]  status
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [3:0]   icode_q, icode_d, ifun_q, ifun_d;
  logic [3:0]   ra_q, ra_d, rb_q, rb_d;
  logic [31:0]  valc_q, valc_d, valp_q, valp_d;
  logic [1:0]   status_q, status_d;
  logic [2:0]   idx_q, idx_d;

  logic [3:0]   dec_icode;
  logic         dec_need_reg, dec_need_const, dec_invalid;
  logic [2:0]   dec_length;
  logic         fire;

  // In OP the decoder looks at the byte arriving now; later states use the latched icode.
  assign dec_icode = (state_q == StOp) ? imem_rdata[7:4] : icode_q;

  instr_len u_instr_len (
    .icode      (dec_icode),
    .need_reg   (dec_need_reg),
    .need_const (dec_need_const),
    .length     (dec_length),
    .invalid    (dec_invalid)
  );

  assign imem_req  = !rst && (state_q == StOp || state_q == StReg || state_q == StConst);
  assign imem_addr = pc_q + {29'b0, idx_q};
  assign out_valid = !rst && (state_q == StIssue);
  assign fire      = imem_req && imem_ack;

  assign icode  = icode_q;
  assign ifun   = ifun_q;
  assign rA     = ra_q;
  assign rB     = rb_q;
  assign valC   = valc_q;
  assign valP   = valp_q;
  assign status = status_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    icode_d  = icode_q;
    ifun_d   = ifun_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    valc_d   = valc_q;
    valp_d   = valp_q;
    status_d = status_q;
    idx_d    = idx_q;
    unique case (state_q)
      StOp: begin
        if (fire) begin
          icode_d = imem_rdata[7:4];
          ifun_d  = imem_rdata[3:0];
          ra_d    = RNONE;
          rb_d    = RNONE;
          valc_d  = 32'h0;
          valp_d  = pc_q + {29'b0, dec_length};
          idx_d   = 3'd1;
          if (dec_invalid) begin
            status_d = STAT_INS;
            state_d  = StIssue;
          end else begin
            status_d = (imem_rdata[7:4] == IHALT) ? STAT_HLT : STAT_AOK;
            if (dec_need_reg)        state_d = StReg;
            else if (dec_need_const) state_d = StConst;
            else                     state_d = StIssue;
          end
        end
      end
      StReg: begin
        if (fire) begin
          ra_d    = imem_rdata[7:4];
          rb_d    = imem_rdata[3:0];
          idx_d   = idx_q + 3'd1;
          state_d = dec_need_const ? StConst : StIssue;
        end
      end
      StConst: begin
        if (fire) begin
          // Shift in from the top so the first (least significant) byte lands in [7:0].
          valc_d = {imem_rdata, valc_q[31:8]};
          idx_d  = idx_q + 3'd1;
          if (idx_q == dec_length - 3'd1) state_d = StIssue;
        end
      end
      StIssue: begin
        if (out_ready) begin
          pc_d    = valp_q;
          idx_d   = 3'd0;
          state_d = (status_q == STAT_AOK) ? StOp : StStop;
        end
      end
      StStop: ;
      default: state_d = StOp;
    endcase
    if (pc_load) begin
      pc_d    = pc_new;
      idx_d   = 3'd0;
      state_d = StOp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StOp;
      pc_q     <= RESET_PC;
      icode_q  <= 4'h0;
      ifun_q   <= 4'h0;
      ra_q     <= RNONE;
      rb_q     <= RNONE;
      valc_q   <= 32'h0;
      valp_q   <= 32'h0;
      status_q <= STAT_AOK;
      idx_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      icode_q  <= icode_d;
      ifun_q   <= ifun_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      valc_q   <= valc_d;
      valp_q   <= valp_d;
      status_q <= status_d;
      idx_q    <= idx_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: byte memory model, scoreboard of expected
// issued instructions, and per-scenario tasks with cycle-accurate checks.
module tb_fetch_unit;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [31:0] valc;
    logic [31:0] valp;
    logic [1:0]  status;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [7:0]  imem_rdata;
  logic        pc_load;
  logic [31:0] pc_new;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  icode, ifun, rA, rB;
  logic [31:0] valC, valP;
  logic [1:0]  status;

  logic [7:0]  mem [256];
  logic        ack_en;
  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  assign imem_ack   = ack_en;
  assign imem_rdata = mem[imem_addr[7:0]];

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc_load    (pc_load),
    .pc_new     (pc_new),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .icode      (icode),
    .ifun       (ifun),
    .rA         (rA),
    .rB         (rB),
    .valC       (valC),
    .valP       (valP),
    .status     (status)
  );

  // Scoreboard: every transfer pops and compares the oldest expected instruction.
  always @(negedge clk) begin
    exp_t got, want;
    if (!rst && out_valid && out_ready) begin
      got = {icode, ifun, rA, rB, valC, valP, status};
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_issue: got %h, required no transfer", got);
      end else begin
        want = sb.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("FAIL issue_fields: got icode=%h ifun=%h rA=%h rB=%h valC=%h valP=%h st=%0d, required icode=%h ifun=%h rA=%h rB=%h valC=%h valP=%h st=%0d",
                   got.icode, got.ifun, got.ra, got.rb, got.valc, got.valp, got.status,
                   want.icode, want.ifun, want.ra, want.rb, want.valc, want.valp, want.status);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pc_load = 1'b0;
    pc_new = 32'h0;
    out_ready = 1'b1;
    ack_en = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(output int left);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    left = sb.size();
  endtask

  task automatic test_reset();
    int left;
    clear_mem();
    mem[0] = 8'h10;
    rst = 1'b1;
    pc_load = 1'b0;
    pc_new = 32'h0;
    out_ready = 1'b1;
    ack_en = 1'b1;
    sb.delete();
    cyc();
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: got req=%b valid=%b, required 0 0", imem_req, out_valid);
    end
    n_checks++;
    if ({icode, ifun, rA, rB, valC, valP, status} !== {4'h0, 4'h0, 4'hF, 4'hF, 32'h0, 32'h0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_fields: got %h %h %h %h %h %h %0d, required 0 0 f f 0 0 0",
               icode, ifun, rA, rB, valC, valP, status);
    end
    cyc();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL first_req: got req=%b addr=%h, required 1 00000000", imem_req, imem_addr);
    end
    sb.push_back('{4'h1, 4'h0, 4'hF, 4'hF, 32'h0, 32'h1, 2'd0});
    sb.push_back('{4'h0, 4'h0, 4'hF, 4'hF, 32'h0, 32'h2, 2'd1});
    drain(left);
  endtask

  task automatic test_nop();
    int left;
    logic stuck;
    clear_mem();
    mem[0] = 8'h10;
    mem[1] = 8'h00;
    do_reset();
    sb.push_back('{4'h1, 4'h0, 4'hF, 4'hF, 32'h0, 32'h1, 2'd0});
    sb.push_back('{4'h0, 4'h0, 4'hF, 4'hF, 32'h0, 32'h2, 2'd1});
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL nop_cycle1: got valid=%b req=%b addr=%h, required 0 1 0", out_valid, imem_req, imem_addr);
    end
    cyc();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL nop_cycle2_valid: got %b, required 1", out_valid);
    end
    cyc();
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h1) begin
      n_fail++;
      $display("FAIL nop_next_fetch: got req=%b addr=%h, required 1 00000001", imem_req, imem_addr);
    end
    cyc();
    cyc();
    stuck = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (imem_req !== 1'b0 || out_valid !== 1'b0) stuck = 1'b1;
      cyc();
    end
    n_checks++;
    if (stuck) begin
      n_fail++;
      $display("FAIL halt_stop: got activity after halt, required req=0 valid=0");
    end
    drain(left);
    n_checks++;
    if (left != 0) begin
      n_fail++;
      $display("FAIL nop_drain: got %0d pending, required 0", left);
    end
  endtask

  task automatic test_irmovl();
    int left;
    logic [7:0] prog [6];
    prog = '{8'h30, 8'hF2, 8'h78, 8'h56, 8'h34, 8'h12};
    clear_mem();
    for (int i = 0; i < 6; i++) mem[i] = prog[i];
    do_reset();
    sb.push_back('{4'h3, 4'h0, 4'hF, 4'h2, 32'h12345678, 32'h6, 2'd0});
    sb.push_back('{4'h0, 4'h0, 4'hF, 4'hF, 32'h0, 32'h7, 2'd1});
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== i) begin
        n_fail++;
        $display("FAIL irmovl_addr%0d: got req=%b addr=%h, required 1 %h", i, imem_req, imem_addr, i);
      end
      cyc();
    end
    drain(left);
    n_checks++;
    if (left != 0) begin
      n_fail++;
      $display("FAIL irmovl_drain: got %0d pending, required 0", left);
    end
  endtask

  task automatic test_stall();
    int left;
    logic bad;
    clear_mem();
    mem[0] = 8'h60;
    mem[1] = 8'h12;
    do_reset();
    out_ready = 1'b0;
    sb.push_back('{4'h6, 4'h0, 4'h1, 4'h2, 32'h0, 32'h2, 2'd0});
    sb.push_back('{4'h0, 4'h0, 4'hF, 4'hF, 32'h0, 32'h3, 2'd1});
    cyc();
    cyc();
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || imem_req !== 1'b0 ||
          {icode, ifun, rA, rB, valC, valP, status} !==
          {4'h6, 4'h0, 4'h1, 4'h2, 32'h0, 32'h2, 2'd0}) bad = 1'b1;
      cyc();
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL stall_hold: got unstable outputs or req during stall, required held OPl with req=0");
    end
    out_ready = 1'b1;
    cyc();
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h2) begin
      n_fail++;
      $display("FAIL stall_next_fetch: got req=%b addr=%h, required 1 00000002", imem_req, imem_addr);
    end
    drain(left);
  endtask

  task automatic test_redirect();
    int left;
    clear_mem();
    mem[0] = 8'h70; mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h33; mem[4] = 8'h44;
    mem[8'h40] = 8'h10;
    do_reset();
    sb.push_back('{4'h1, 4'h0, 4'hF, 4'hF, 32'h0, 32'h41, 2'd0});
    sb.push_back('{4'h0, 4'h0, 4'hF, 4'hF, 32'h0, 32'h42, 2'd1});
    cyc();
    cyc();
    cyc();
    pc_load = 1'b1;
    pc_new = 32'h40;
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h3) begin
      n_fail++;
      $display("FAIL redirect_const2: got req=%b addr=%h, required 1 00000003", imem_req, imem_addr);
    end
    cyc();
    pc_load = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL redirect_target: got valid=%b req=%b addr=%h, required 0 1 00000040",
               out_valid, imem_req, imem_addr);
    end
    drain(left);
    n_checks++;
    if (left != 0) begin
      n_fail++;
      $display("FAIL redirect_drain: got %0d pending, required 0", left);
    end
  endtask

  task automatic test_invalid();
    int left;
    logic bad;
    clear_mem();
    mem[0] = 8'hC0;
    mem[8'h20] = 8'h10;
    do_reset();
    sb.push_back('{4'hC, 4'h0, 4'hF, 4'hF, 32'h0, 32'h1, 2'd2});
    cyc();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || status !== 2'd2) begin
      n_fail++;
      $display("FAIL ins_issue: got valid=%b status=%0d, required 1 2", out_valid, status);
    end
    cyc();
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ins_stop: got req=%b valid=%b, required 0 0", imem_req, out_valid);
    end
    cyc();
    sb.push_back('{4'h0, 4'h0, 4'hF, 4'hF, 32'h0, 32'h11, 2'd1});
    pc_load = 1'b1;
    pc_new = 32'h10;
    cyc();
    pc_load = 1'b0;
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL stop_reload: got req=%b addr=%h, required 1 00000010", imem_req, imem_addr);
    end
    cyc();
    cyc();
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (imem_req !== 1'b0 || out_valid !== 1'b0) bad = 1'b1;
      cyc();
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL hlt_stop: got activity after halt, required req=0 valid=0");
    end
    sb.push_back('{4'h1, 4'h0, 4'hF, 4'hF, 32'h0, 32'h21, 2'd0});
    sb.push_back('{4'h0, 4'h0, 4'hF, 4'hF, 32'h0, 32'h22, 2'd1});
    pc_load = 1'b1;
    pc_new = 32'h20;
    cyc();
    pc_load = 1'b0;
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin
      n_fail++;
      $display("FAIL stop_reload2: got req=%b addr=%h, required 1 00000020", imem_req, imem_addr);
    end
    drain(left);
    n_checks++;
    if (left != 0) begin
      n_fail++;
      $display("FAIL invalid_drain: got %0d pending, required 0", left);
    end
  endtask

  task automatic test_reset_mid();
    int left;
    clear_mem();
    mem[0] = 8'h30; mem[1] = 8'hF2; mem[2] = 8'h78;
    mem[3] = 8'h56; mem[4] = 8'h34; mem[5] = 8'h12;
    do_reset();
    cyc();
    cyc();
    cyc();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_cycle: got req=%b valid=%b, required 0 0", imem_req, out_valid);
    end
    cyc();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({icode, ifun, rA, rB, valC, valP, status, out_valid, imem_req, imem_addr} !==
        {4'h0, 4'h0, 4'hF, 4'hF, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL midrst_state: got %h %h %h %h %h %h %0d v=%b r=%b a=%h, required reset values, req at 0",
               icode, ifun, rA, rB, valC, valP, status, out_valid, imem_req, imem_addr);
    end
    sb.push_back('{4'h3, 4'h0, 4'hF, 4'h2, 32'h12345678, 32'h6, 2'd0});
    sb.push_back('{4'h0, 4'h0, 4'hF, 4'hF, 32'h0, 32'h7, 2'd1});
    drain(left);
    n_checks++;
    if (left != 0) begin
      n_fail++;
      $display("FAIL midrst_drain: got %0d pending, required 0", left);
    end
  endtask

  task automatic test_back_to_back();
    int left;
    int seen[$];
    int want[4];
    want = '{2, 5, 12, 14};
    clear_mem();
    mem[0] = 8'h10;
    mem[1] = 8'h20; mem[2] = 8'h12;
    mem[3] = 8'h30; mem[4] = 8'hF3; mem[5] = 8'h01;
    do_reset();
    sb.push_back('{4'h1, 4'h0, 4'hF, 4'hF, 32'h0, 32'h1, 2'd0});
    sb.push_back('{4'h2, 4'h0, 4'h1, 4'h2, 32'h0, 32'h3, 2'd0});
    sb.push_back('{4'h3, 4'h0, 4'hF, 4'h3, 32'h1, 32'h9, 2'd0});
    sb.push_back('{4'h0, 4'h0, 4'hF, 4'hF, 32'h0, 32'hA, 2'd1});
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (out_valid) seen.push_back(c);
      cyc();
    end
    n_checks++;
    if (seen.size() != 4) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d issues, required 4", seen.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (seen[i] != want[i]) begin
          n_fail++;
          $display("FAIL b2b_cycle%0d: got cycle %0d, required %0d", i, seen[i], want[i]);
        end
      end
    end
    drain(left);
  endtask

  initial begin
    rst = 1'b1;
    pc_load = 1'b0;
    pc_new = 32'h0;
    out_ready = 1'b1;
    ack_en = 1'b0;
    test_reset();
    test_nop();
    test_irmovl();
    test_stall();
    test_redirect();
    test_invalid();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0, giving the PC loaded on reset.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port imem_req, output, 1 bit: byte read request to instruction memory.
REQ-005 SHALL have port imem_addr, output, 32 bits: byte address; held stable while imem_req=1 and imem_ack=0.
REQ-006 SHALL have port imem_ack, input, 1 bit: imem_rdata valid this cycle; a byte transfers on imem_req & imem_ack.
REQ-007 SHALL have port imem_rdata, input, 8 bits: returned byte.
REQ-008 SHALL have ports pc_load (input, 1 bit) and pc_new (input, 32 bits): redirect from the jump/call/ret path.
REQ-009 SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit): handshake to execute; transfer on out_valid & out_ready.
REQ-010 SHALL have outputs icode[3:0], ifun[3:0], rA[3:0], rB[3:0], valC[31:0], valP[31:0]: decoded instruction fields.
REQ-011 SHALL have output status[1:0]: AOK=0, HLT=1, INS=2.

Function
REQ-012 SHALL implement FSM states OP, REG, CONST, ISSUE, STOP.
REQ-013 OP: fetch byte at pc; latch icode=byte[7:4], ifun=byte[3:0]; go to REG, CONST or ISSUE according to the encoding.
REQ-014 SHALL fetch a register byte (rA=[7:4], rB=[3:0]) for icode 2,3,4,5,6,A,B; rA=rB=4'hF otherwise.
REQ-015 SHALL fetch 4 constant bytes for icode 3,4,5,7,8, little-endian (first byte -> valC[7:0]); valC=0 otherwise.
REQ-016 Instruction length: 1 for icode 0,1,9; 2 for 2,6,A,B; 5 for 7,8; 6 for 3,4,5; valP=pc+length, modulo 2^32.
REQ-017 icode >= 4'hC: SHALL issue with status=INS, valP=pc+1, then enter STOP.
REQ-018 icode 0 (halt): SHALL issue with status=HLT, then enter STOP; all others issue with status=AOK.
REQ-019 ISSUE: out_valid=1; all outputs held stable until out_ready; on transfer pc<=valP and go to OP in the same cycle.
REQ-020 Latency: zero-wait memory (ack every cycle) and out_ready=1: out_valid rises the cycle after the final byte is acked; sustains one instruction per length+1 cycles.
REQ-021 STOP: imem_req=0, out_valid=0; left only by reset or pc_load.
REQ-022 pc_load in any state SHALL abort the current fetch and any un-transferred output, set pc<=pc_new, and enter OP next cycle; any byte acked in that cycle is discarded.
REQ-023 pc_load coincident with an output transfer: the transfer completes; the redirect still wins for pc.
REQ-024 imem_req SHALL be 0 in ISSUE and STOP, 1 in OP/REG/CONST.
REQ-025 imem_addr SHALL equal pc+byte_index (0..5) of the byte being fetched.

Reset
REQ-026 On rst: pc=RESET_PC, state=OP, out_valid=0, imem_req=0 in the reset cycle, icode=ifun=0, rA=rB=4'hF, valC=0, valP=0, status=AOK.
REQ-027 rst mid-fetch or mid-issue SHALL discard all partial state; any ack in the reset cycle is ignored.
REQ-028 First imem_req SHALL assert the cycle after rst deasserts, at RESET_PC.

Structure
REQ-029 Icode constants (IHALT..IPOPL), status codes, and function/condition codes SHALL live in a shared package also used by execute.
REQ-030 Length/field-presence decode SHALL be a combinational sub-module instr_len (icode -> need_reg, need_const, length, invalid).

Verification
REQ-031 nop (0x10) at 0, zero-wait, out_ready=1 -> out_valid at cycle 2 after reset release: icode=1, valP=1, status=AOK.
REQ-032 irmovl bytes 30 F2 78 56 34 12 -> rA=F, rB=2, valC=0x12345678, valP=6; addresses 0..5 requested in order.
REQ-033 OPl 0x60 0x12 with out_ready=0 for 5 cycles -> outputs stable, no imem_req until transfer; next fetch at 2.
REQ-034 pc_load=1, pc_new=0x40 during the third constant byte of a jXX -> no issue of the jXX; next request at 0x40.
REQ-035 Byte 0xC0 -> status=INS, valP=pc+1, then imem_req=0; byte 0x00 -> status=HLT, then STOP until pc_load.
REQ-036 rst asserted mid-CONST with ack pending -> all outputs at reset values; refetch starts at RESET_PC.
